// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner tags,
// memory access-size codes and the latched request record.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    // Access-size codes carried on *_wstrb, shared with memory_access.
    typedef enum logic [1:0] {
        WSTRB_BYTE = 2'b00,
        WSTRB_HALF = 2'b01,
        WSTRB_WORD = 2'b10
    } wstrb_t;

    typedef struct packed {
        arb_owner_t          owner;
        logic [ADDR_W-1:0]   addr;
        logic                we;
        logic [DATA_W-1:0]   wdata;
        logic [1:0]          wstrb;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: I-port, D-port and memory-side handshakes.
// slave is the arbiter's view; master is the environment (requesters + memory).
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_addr;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_wstrb;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req_valid;
    logic              m_req_ready;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [1:0]        m_wstrb;
    logic              m_resp_valid;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req_valid, i_addr,
        output i_req_ready, i_resp_valid, i_rdata,
        input  d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
        output d_req_ready, d_resp_valid, d_rdata,
        output m_req_valid, m_addr, m_we, m_wdata, m_wstrb,
        input  m_req_ready, m_resp_valid, m_rdata
    );

    modport master (
        output i_req_valid, i_addr,
        input  i_req_ready, i_resp_valid, i_rdata,
        output d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
        input  d_req_ready, d_resp_valid, d_rdata,
        input  m_req_valid, m_addr, m_we, m_wdata, m_wstrb,
        output m_req_ready, m_resp_valid, m_rdata
    );

endinterface

// File: rtl/mem_arb_picker.sv
// Winner selection between I and D requesters with a bounded D-priority streak
// so that a continuously busy D port cannot starve instruction fetch.
module mem_arb_picker
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_valid_i,
    input  logic d_valid_i,
    input  logic grant_en_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] d_streak_q;
    logic [SW-1:0] d_streak_d;

    always_comb begin
        grant_d_o  = grant_en_i && d_valid_i && (!i_valid_i || (d_streak_q != STREAK_MAX));
        grant_i_o  = grant_en_i && i_valid_i && !grant_d_o;
        d_streak_d = d_streak_q;
        // Only D wins that actually made I wait count towards the streak.
        if (grant_d_o && i_valid_i) begin
            if (d_streak_q != STREAK_MAX) begin
                d_streak_d = d_streak_q + SW'(1);
            end
        end else if (grant_d_o || grant_i_o) begin
            d_streak_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_streak_q <= '0;
        end else begin
            d_streak_q <= d_streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between I-fetch and D-access.
// Accepts in IDLE, presents the latched request in REQ, routes the response in WAIT.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         busy
);

    arb_state_t state_q;
    arb_req_t   req_q;
    logic       m_req_valid_q;
    logic       busy_q;
    logic       grant_i;
    logic       grant_d;
    logic       resp_hit;

    // Readies are held low while reset is asserted even though the state is IDLE.
    mem_arb_picker #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_picker (
        .clock      (clock),
        .reset      (reset),
        .i_valid_i  (bus.i_req_valid),
        .d_valid_i  (bus.d_req_valid),
        .grant_en_i ((state_q == IDLE) && !reset),
        .grant_i_o  (grant_i),
        .grant_d_o  (grant_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= '0;
            m_req_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        req_q <= '{owner: OWNER_D, addr: bus.d_addr, we: bus.d_we,
                                   wdata: bus.d_wdata, wstrb: bus.d_wstrb};
                    end else if (grant_i) begin
                        req_q <= '{owner: OWNER_I, addr: bus.i_addr, we: 1'b0,
                                   wdata: '0, wstrb: WSTRB_WORD};
                    end
                    if (grant_d || grant_i) begin
                        state_q       <= REQ;
                        m_req_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.m_req_ready) begin
                        state_q       <= WAIT;
                        m_req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.m_resp_valid) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    m_req_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_req_ready = grant_i;
    assign bus.d_req_ready = grant_d;

    assign bus.m_req_valid = m_req_valid_q;
    assign bus.m_addr      = req_q.addr;
    assign bus.m_we        = req_q.we;
    assign bus.m_wdata     = req_q.wdata;
    assign bus.m_wstrb     = req_q.wstrb;
    assign busy            = busy_q;

    // Responses outside WAIT are stray and never reach a requester.
    assign resp_hit = (state_q == WAIT) && bus.m_resp_valid;

    always_comb begin
        bus.i_resp_valid = resp_hit && (req_q.owner == OWNER_I);
        bus.d_resp_valid = resp_hit && (req_q.owner == OWNER_D);
        bus.i_rdata      = bus.i_resp_valid ? bus.m_rdata : '0;
        bus.d_rdata      = bus.d_resp_valid ? bus.m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: idle-selection table, directed multi-cycle sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXD = 4;

    logic clock = 1'b0;
    logic reset;
    logic busy;
    int   n_pass = 0;
    int   n_chk  = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_D_STREAK(MAXD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic iv;
        logic dv;
        logic ir;
        logic dr;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, m_req_valid, busy}
    function automatic logic [5:0] ctl();
        return {bus.i_req_ready, bus.d_req_ready, bus.i_resp_valid,
                bus.d_resp_valid, bus.m_req_valid, busy};
    endfunction

    function automatic logic [66:0] mfields();
        return {bus.m_addr, bus.m_we, bus.m_wdata, bus.m_wstrb};
    endfunction

    function automatic logic [63:0] rdata();
        return {bus.i_rdata, bus.d_rdata};
    endfunction

    task automatic idle_inputs();
        bus.i_req_valid  = 1'b0;
        bus.i_addr       = '0;
        bus.d_req_valid  = 1'b0;
        bus.d_addr       = '0;
        bus.d_we         = 1'b0;
        bus.d_wdata      = '0;
        bus.d_wstrb      = 2'b00;
        bus.m_req_ready  = 1'b0;
        bus.m_resp_valid = 1'b0;
        bus.m_rdata      = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [5:0] ord;
        int         grants;
        int         phase;
        int         streak;
        logic       rec_d, rec_we, i_acc, d_acc, want_i, want_d;
        logic [31:0] rec_addr, rec_wdata;
        logic [1:0]  rec_wstrb;
        logic [5:0]  exp_ctl;
        logic [63:0] exp_rd;

        // Reset with every input active: nothing may leak to the outputs.
        idle_inputs();
        reset = 1'b1;
        bus.i_req_valid  = 1'b1;
        bus.d_req_valid  = 1'b1;
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'hFFFF_FFFF;
        @(negedge clock);
        check("reset ctl", 128'(ctl()), 128'(6'b000000));
        check("reset rdata", 128'(rdata()), 128'(64'h0));
        check("reset fields", 128'(mfields()), 128'(67'h0));

        // Idle winner selection with streak 0, no clock edge between vectors.
        tbl[0] = '{iv: 1'b0, dv: 1'b0, ir: 1'b0, dr: 1'b0};
        tbl[1] = '{iv: 1'b1, dv: 1'b0, ir: 1'b1, dr: 1'b0};
        tbl[2] = '{iv: 1'b0, dv: 1'b1, ir: 1'b0, dr: 1'b1};
        tbl[3] = '{iv: 1'b1, dv: 1'b1, ir: 1'b0, dr: 1'b1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.i_req_valid = tbl[k].iv;
            bus.d_req_valid = tbl[k].dv;
            #1;
            check($sformatf("pick[%0d]", k), 128'({bus.i_req_ready, bus.d_req_ready}),
                  128'({tbl[k].ir, tbl[k].dr}));
        end
        idle_inputs();

        // I-only read with minimum latency; i_addr changes after accept are ignored.
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h100;
        bus.m_req_ready = 1'b1;
        @(negedge clock);
        check("iread accept", 128'(ctl()), 128'(6'b100000));
        step();
        bus.i_addr = 32'h7777;
        @(negedge clock);
        check("iread req ctl", 128'(ctl()), 128'(6'b000011));
        check("iread req fields", 128'(mfields()), 128'({32'h100, 1'b0, 32'h0, 2'b10}));
        step();
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'hDEADBEEF;
        @(negedge clock);
        check("iread resp ctl", 128'(ctl()), 128'(6'b001001));
        check("iread resp data", 128'(rdata()), 128'({32'hDEADBEEF, 32'h0}));
        step();
        bus.m_resp_valid = 1'b0;
        @(negedge clock);
        check("iread next accept", 128'(ctl()), 128'(6'b100000));

        // Simultaneous I read and D write: D first, then I.
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h300;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h200;
        bus.d_we        = 1'b1;
        bus.d_wdata     = 32'h12345678;
        bus.d_wstrb     = 2'b10;
        bus.m_req_ready = 1'b1;
        @(negedge clock);
        check("both accept", 128'(ctl()), 128'(6'b010000));
        step();
        bus.d_req_valid = 1'b0;
        @(negedge clock);
        check("both dreq ctl", 128'(ctl()), 128'(6'b000011));
        check("both dreq fields", 128'(mfields()), 128'({32'h200, 1'b1, 32'h12345678, 2'b10}));
        step();
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'h55;
        @(negedge clock);
        check("both dresp ctl", 128'(ctl()), 128'(6'b000101));
        check("both dresp data", 128'(rdata()), 128'({32'h0, 32'h55}));
        step();
        bus.m_resp_valid = 1'b0;
        @(negedge clock);
        check("both iaccept", 128'(ctl()), 128'(6'b100000));
        step();
        bus.i_req_valid = 1'b0;
        @(negedge clock);
        check("both ireq fields", 128'(mfields()), 128'({32'h300, 1'b0, 32'h0, 2'b10}));
        step();
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'h66;
        @(negedge clock);
        check("both iresp ctl", 128'(ctl()), 128'(6'b001001));
        check("both iresp data", 128'(rdata()), 128'({32'h66, 32'h0}));
        step();

        // Starvation bound: both held valid, memory always ready and responding.
        do_reset();
        bus.i_req_valid  = 1'b1;
        bus.d_req_valid  = 1'b1;
        bus.m_req_ready  = 1'b1;
        bus.m_resp_valid = 1'b1;
        ord    = '0;
        grants = 0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            @(negedge clock);
            if (bus.d_req_ready || bus.i_req_ready) begin
                ord[grants] = bus.d_req_ready;
                grants++;
            end
        end
        check("starve grants", 128'(grants), 128'(6));
        check("starve order", 128'(ord), 128'(6'b101111));

        // Backpressure: five cycles with m_req_ready low, D address changing meanwhile.
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h400;
        @(negedge clock);
        check("bp accept", 128'(ctl()), 128'(6'b010000));
        step();
        bus.d_addr = 32'h999;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("bp hold ctl[%0d]", k), 128'(ctl()), 128'(6'b000011));
            check($sformatf("bp hold fields[%0d]", k), 128'(mfields()),
                  128'({32'h400, 1'b0, 32'h0, 2'b00}));
            step();
        end
        bus.m_req_ready = 1'b1;
        @(negedge clock);
        check("bp release", 128'(ctl()), 128'(6'b000011));
        step();
        bus.m_req_ready  = 1'b0;
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'hA5;
        @(negedge clock);
        check("bp resp", 128'(ctl()), 128'(6'b000101));
        step();

        // Reset while waiting for the response; the late response is dropped.
        do_reset();
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h500;
        bus.m_req_ready = 1'b1;
        step();
        bus.i_req_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("rstwait ctl", 128'(ctl()), 128'(6'b000000));
        check("rstwait fields", 128'(mfields()), 128'(67'h0));
        @(posedge clock);
        #1 reset = 1'b0;
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'h77;
        @(negedge clock);
        check("late resp ctl", 128'(ctl()), 128'(6'b000000));
        check("late resp data", 128'(rdata()), 128'(64'h0));
        step();
        bus.m_resp_valid = 1'b0;
        bus.i_req_valid  = 1'b1;
        @(negedge clock);
        check("post rst accept", 128'(ctl()), 128'(6'b100000));

        // Spurious responses in IDLE and REQ, then the real one routed once.
        do_reset();
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'h11;
        @(negedge clock);
        check("spur idle ctl", 128'(ctl()), 128'(6'b000000));
        check("spur idle data", 128'(rdata()), 128'(64'h0));
        step();
        bus.m_resp_valid = 1'b0;
        bus.i_req_valid  = 1'b1;
        bus.i_addr       = 32'h600;
        step();
        bus.i_req_valid  = 1'b0;
        bus.m_resp_valid = 1'b1;
        @(negedge clock);
        check("spur req ctl", 128'(ctl()), 128'(6'b000011));
        check("spur req data", 128'(rdata()), 128'(64'h0));
        step();
        bus.m_resp_valid = 1'b0;
        bus.m_req_ready  = 1'b1;
        step();
        bus.m_req_ready  = 1'b0;
        bus.m_resp_valid = 1'b1;
        bus.m_rdata      = 32'hAAAA5555;
        @(negedge clock);
        check("spur real ctl", 128'(ctl()), 128'(6'b001001));
        check("spur real data", 128'(rdata()), 128'({32'hAAAA5555, 32'h0}));
        step();
        @(negedge clock);
        check("spur after ctl", 128'(ctl()), 128'(6'b000000));
        step();

        // Randomized traffic against a transaction-level model.
        do_reset();
        phase  = 0;
        streak = 0;
        i_acc  = 1'b0;
        d_acc  = 1'b0;
        rec_d = 1'b0; rec_we = 1'b0; rec_addr = '0; rec_wdata = '0; rec_wstrb = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (i_acc || !bus.i_req_valid) begin
                bus.i_req_valid = 1'($urandom % 2);
                bus.i_addr      = $urandom;
            end
            if (d_acc || !bus.d_req_valid) begin
                bus.d_req_valid = 1'($urandom % 2);
                bus.d_addr      = $urandom;
                bus.d_we        = 1'($urandom % 2);
                bus.d_wdata     = $urandom;
                bus.d_wstrb     = 2'($urandom_range(0, 2));
            end
            bus.m_req_ready  = 1'($urandom % 2);
            bus.m_resp_valid = ($urandom % 3) == 0;
            bus.m_rdata      = $urandom;
            @(negedge clock);
            i_acc   = 1'b0;
            d_acc   = 1'b0;
            exp_ctl = '0;
            exp_rd  = '0;
            want_d  = bus.d_req_valid && (!bus.i_req_valid || streak < MAXD);
            want_i  = bus.i_req_valid && !want_d;
            if (phase == 0) begin
                exp_ctl = {want_i, want_d, 4'b0000};
            end else if (phase == 1) begin
                exp_ctl = 6'b000011;
            end else begin
                exp_ctl = {2'b00, bus.m_resp_valid && !rec_d, bus.m_resp_valid && rec_d, 2'b01};
                if (bus.m_resp_valid) exp_rd = rec_d ? {32'h0, bus.m_rdata} : {bus.m_rdata, 32'h0};
            end
            check("rand ctl", 128'(ctl()), 128'(exp_ctl));
            check("rand rdata", 128'(rdata()), 128'(exp_rd));
            if (phase == 1)
                check("rand fields", 128'(mfields()),
                      128'({rec_addr, rec_we, rec_wdata, rec_wstrb}));
            if (phase == 0 && (want_d || want_i)) begin
                rec_d     = want_d;
                rec_addr  = want_d ? bus.d_addr : bus.i_addr;
                rec_we    = want_d ? bus.d_we : 1'b0;
                rec_wdata = want_d ? bus.d_wdata : 32'h0;
                rec_wstrb = want_d ? bus.d_wstrb : 2'b10;
                if (want_d && bus.i_req_valid) streak = (streak < MAXD) ? streak + 1 : MAXD;
                else streak = 0;
                i_acc = want_i;
                d_acc = want_d;
                phase = 1;
            end else if (phase == 1 && bus.m_req_ready) begin
                phase = 2;
            end else if (phase == 2 && bus.m_resp_valid) begin
                phase = 0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
